// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect and stale-request draining
//
// Purpose: issues word-aligned reads to instruction memory, holds each returned
// word for decode, and follows decoder redirects. A redirect that lands while a
// read is still outstanding keeps that read on the bus until it is acked, then
// throws its data away.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   imem_req/imem_addr    read request and word address to instruction memory
//   imem_ack/imem_rdata   read completion and returned word
//   instr/instr_valid     held instruction to decode and its valid flag
//   instr_ready           decode consumes instr this cycle
//   pc_out/pc_plus8       address of instr, and that address plus 8
//   redirect/redirect_tgt new fetch target from decode (low two bits dropped)
//   misalign              sticky: a redirect target had nonzero low bits
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_imem_addr;
  logic        r_imem_req;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_instr_valid;
  logic        r_misalign;

  logic [31:0] w_target;
  logic        w_target_bad;

  assign w_target     = redirect_target & ~32'h3;
  assign w_target_bad = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_imem_addr   <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr       <= 32'h0;
      r_pc_out      <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      if (redirect && w_target_bad) begin
        r_misalign <= 1'b1;
      end

      case (r_state)
        S_REQ: begin
          if (!r_imem_req) begin
            // First edge after reset release: raise the request; any ack seen
            // now belongs to no request of ours and is ignored.
            r_imem_req <= 1'b1;
            if (redirect) begin
              r_fetch_pc  <= w_target;
              r_imem_addr <= w_target;
            end
          end else if (redirect) begin
            r_fetch_pc <= w_target;
            if (imem_ack) begin
              // Read completes on the redirect edge: drop the data and
              // start the new request straight away.
              r_imem_addr <= w_target;
            end else begin
              // Outstanding read cannot be abandoned; keep its address on the
              // bus until it completes.
              r_state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            r_fetch_pc    <= w_target;
            r_imem_addr   <= w_target;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end else if (instr_ready) begin
            r_imem_addr   <= r_fetch_pc;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (redirect) begin
            r_fetch_pc <= w_target;
          end
          if (imem_ack) begin
            // Newest target wins, including one arriving on the ack edge.
            r_imem_addr <= redirect ? w_target : r_fetch_pc;
            r_state     <= S_REQ;
          end
        end

        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc_out;
  assign pc_plus8    = r_pc_out + 32'd8;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (two reset PCs)
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  logic        req_a, valid_a, mis_a;
  logic [31:0] addr_a, instr_a, pc_a, pc8_a;
  logic        req_b, valid_b, mis_b;
  logic [31:0] addr_b, instr_b, pc_b, pc8_b;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(reset),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr_a), .instr_valid(valid_a), .instr_ready(instr_ready),
    .pc_out(pc_a), .pc_plus8(pc8_a),
    .redirect(redirect), .redirect_target(redirect_target), .misalign(mis_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .reset(reset),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr_b), .instr_valid(valid_b), .instr_ready(instr_ready),
    .pc_out(pc_b), .pc_plus8(pc8_b),
    .redirect(redirect), .redirect_target(redirect_target), .misalign(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level view of the fetch stage: one memory read in flight or
  // one instruction held, plus a flag marking an in-flight read as unwanted.
  typedef struct {
    logic        started;
    logic        req;
    logic [31:0] addr;
    logic        stale;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic [31:0] next_pc;
    logic        mis;
  } model_t;

  model_t m [2];

  function automatic model_t model_init(logic [31:0] rpc);
    model_t n;
    n.started = 1'b0; n.req = 1'b0; n.addr = rpc; n.stale = 1'b0;
    n.valid = 1'b0; n.instr = 32'h0; n.pcout = rpc; n.next_pc = rpc; n.mis = 1'b0;
    return n;
  endfunction

  function automatic model_t model_step(model_t m_in, logic a, logic [31:0] d,
                                        logic rdy, logic rd, logic [31:0] t);
    model_t      n;
    logic [31:0] ta;
    n  = m_in;
    ta = {t[31:2], 2'b00};
    if (rd && t[1:0] != 2'b00) n.mis = 1'b1;
    if (!m_in.started) begin
      n.started = 1'b1;
      n.req     = 1'b1;
      if (rd) n.next_pc = ta;
      n.addr = n.next_pc;
    end else if (m_in.valid) begin
      if (rd) begin
        n.next_pc = ta; n.valid = 1'b0; n.req = 1'b1; n.addr = ta;
      end else if (rdy) begin
        n.valid = 1'b0; n.req = 1'b1; n.addr = m_in.next_pc;
      end
    end else if (a) begin
      if (m_in.stale || rd) begin
        if (rd) n.next_pc = ta;
        n.addr  = n.next_pc;
        n.stale = 1'b0;
      end else begin
        n.instr   = d;
        n.pcout   = m_in.addr;
        n.next_pc = m_in.addr + 32'd4;
        n.valid   = 1'b1;
        n.req     = 1'b0;
      end
    end else if (rd) begin
      n.next_pc = ta;
      n.stale   = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int k);
    logic        r, v, ms;
    logic [31:0] ad, in, pc, p8;
    if (k == 0) begin
      r = req_a; v = valid_a; ms = mis_a; ad = addr_a; in = instr_a; pc = pc_a; p8 = pc8_a;
    end else begin
      r = req_b; v = valid_b; ms = mis_b; ad = addr_b; in = instr_b; pc = pc_b; p8 = pc8_b;
    end
    chk($sformatf("u%0d.imem_req", k), {31'b0, r}, {31'b0, m[k].req});
    if (m[k].req) chk($sformatf("u%0d.imem_addr", k), ad, m[k].addr);
    chk($sformatf("u%0d.instr_valid", k), {31'b0, v}, {31'b0, m[k].valid});
    chk($sformatf("u%0d.instr", k), in, m[k].instr);
    chk($sformatf("u%0d.pc_out", k), pc, m[k].pcout);
    chk($sformatf("u%0d.pc_plus8", k), p8, m[k].pcout + 32'd8);
    chk($sformatf("u%0d.misalign", k), {31'b0, ms}, {31'b0, m[k].mis});
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, check.
  task automatic step(input logic a, input logic [31:0] d, input logic rdy,
                      input logic rd, input logic [31:0] t);
    imem_ack = a; imem_rdata = d; instr_ready = rdy; redirect = rd; redirect_target = t;
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], a, d, rdy, rd, t);
    @(posedge clk);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    m[0] = model_init(32'h0000_0000);
    m[1] = model_init(32'hFFFF_FFFC);

    // Held in reset with an ack on the bus: nothing moves.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all(0);
    check_all(1);

    // Release; ack arrives on the third request cycle.
    reset = 1'b1;
    idle(1);
    chk("first_addr", addr_a, 32'h0);
    chk("first_req", {31'b0, req_a}, 32'h1);
    idle(2);
    step(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
    chk("e2801001_instr", instr_a, 32'hE280_1001);
    chk("e2801001_pc8", pc8_a, 32'h8);
    chk("wrap_pc8", pc8_b, 32'h4);
    idle(2);

    // Streaming: decode always ready, memory acks every request at once.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + i, 1'b1, 1'b0, 32'h0);
    chk("stream_pc", pc_a, 32'h10);
    chk("wrap_stream_pc", pc_b, 32'hC);

    // Redirect while holding an instruction.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    chk("hold_redir_valid", {31'b0, valid_a}, 32'h0);
    chk("hold_redir_addr", addr_a, 32'h100);

    // Redirect with the read outstanding, ack three cycles later.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    idle(2);
    chk("drain_addr", addr_a, 32'h100);
    step(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
    chk("after_drain_addr", addr_a, 32'h200);
    chk("after_drain_valid", {31'b0, valid_a}, 32'h0);

    // Misaligned target.
    step(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h0000_0102);
    chk("mis_addr", addr_a, 32'h100);
    chk("mis_flag", {31'b0, mis_a}, 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), $urandom);
    end

    // Reset asserted mid-cycle while a request is up drops it immediately.
    while (!req_a) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_req_a", {31'b0, req_a}, 32'h0);
    chk("async_req_b", {31'b0, req_b}, 32'h0);
    m[0] = model_init(32'h0000_0000);
    m[1] = model_init(32'hFFFF_FFFC);
    imem_ack = 1'b1;
    @(negedge clk);
    check_all(0);
    check_all(1);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
